fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the PC register and drives the instruction-memory Address input.
//  Selects each cycle between sequential fetch, jump, branch, jr,
//  exception and interrupt vectors.
//  Also handles pipeline stall, the supervisor bit PC[31] and EPC capture.
//  Sits in the IF stage between the hazard/branch logic and the instruction ROM.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded by reset
//  IRQ_VEC    32'h8000_0004  interrupt vector
//  EXC_VEC    32'h8000_0008  exception vector
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   synchronous, active-low reset
//  stall        in   1   hold PC (load-use hazard)
//  jump_en      in   1   J/JAL resolved in ID
//  jump_target  in   32  jump destination
//  branch_en    in   1   taken branch resolved in EX
//  branch_target in  32  branch destination
//  jr_en        in   1   JR/JALR resolved in ID
//  jr_target    in   32  register destination
//  exception    in   1   illegal op / fault reported by pipeline
//  exc_pc       in   32  PC of the faulting instruction
//  irq          in   1   external interrupt request (level)
//  pc           out  32  fetch address -> instruction memory Address
//  pc_plus4     out  32  pc + 4 (link value)
//  fetch_valid  out  1   pc is a real fetch this cycle
//  flush_if     out  1   kill instruction now in IF/ID (combinational)
//  epc          out  32  return address for $k0/$26 writeback
//  epc_we       out  1   one-cycle pulse when epc is updated
//  fetch_cnt    out  32  count of fetches that advanced
// BEHAVIOUR
//  Reset (reset==0 at edge):
//   - pc=RESET_PC, epc=0, epc_we=0, fetch_cnt=0, state=BOOT.
//   - Reset overrides everything, including in mid-redirect.
//  FSM:
//   - BOOT: fetch_valid=0, no redirect accepted; next state RUN.
//   - RUN: fetch_valid=1.
//  Priority, highest first, in RUN:
//   1. exception: pc<=EXC_VEC, epc<=exc_pc.
//   2. irq, only if pc[31]==0: pc<=IRQ_VEC, epc<=next pc that
//      jr/branch/jump/sequential would have selected (ignoring stall).
//   3. jr: pc<=jr_target; if pc[31]==0, target bit31 is forced to 0.
//      User mode cannot enter supervisor mode.
//   4. branch: pc<={pc[31], branch_target[30:0]}.
//   5. jump: pc<={pc[31], jump_target[30:0]}.
//   6. stall: pc and fetch_cnt hold.
//   7. sequential: pc<={pc[31], pc[30:0]+31'd4}; bits 30:0 wrap mod 2^31.
//  Redirects and stall:
//   - Items 1-5 are redirects: they override stall, take effect at the
//     next edge (1-cycle latency) and increment fetch_cnt.
//   - flush_if = RUN & any redirect taken this cycle.
//   - Under stall with no redirect, flush_if=0.
//  Other rules:
//   - epc_we=1 for exactly the cycle after an exception or irq is taken.
//   - epc holds its value otherwise.
//   - pc_plus4 = {pc[31], pc[30:0]+4}, combinational.
//   - fetch_cnt increments on every RUN cycle without a held stall;
//     wraps at 2^32.
//   - irq is ignored while pc[31]==1, BOOT included; it is not latched.
//   - Simultaneous exception and irq: exception wins, irq re-samples later.
// TESTING
//  - Reset: hold reset=0 3 cycles -> pc=0x80000000, fetch_valid=0 one cycle
//    after release, then pc 0x80000004, 0x80000008.
//  - Stall: assert stall 2 cycles at pc=0x8000000C -> pc stays 0x8000000C,
//    fetch_cnt frozen, flush_if=0.
//  - Branch+jump same cycle: branch_target=0x00000040 and
//    jump_target=0x00000080 at pc=0x80000010 -> pc=0x80000040, flush_if=1.
//  - JR privilege: pc=0x00000020, jr_target=0x80000100 -> pc=0x00000100.
//  - IRQ+branch: at user pc=0x00000030 with branch_target=0x00000050 ->
//    pc=0x80000004, epc=0x00000050, epc_we pulse.
//    Same irq with pc=0x80000030 -> ignored.
//  - Exception+irq with stall: exc_pc=0x0000002C -> pc=0x80000008,
//    epc=0x0000002C; reset mid-sequence -> pc=0x80000000.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the IF-stage program counter. Each cycle it picks
// the next fetch address from the exception, interrupt, jr, branch and jump
// requests or the sequential pc+4, honours load-use stalls, keeps user code
// out of supervisor space (pc[31]), and captures the return address in epc.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic [31:0] exc_pc,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        epc_we_q, epc_we_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic        run;
  logic        user_mode;
  logic        irq_take;
  logic        flow_redirect;
  logic        redirect;
  logic [31:0] seq_pc;
  logic [31:0] jr_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] flow_pc;

  // Target bit 31 of jump/branch never reaches pc: the current mode is kept.
  logic        unused_target_msb;
  assign unused_target_msb = jump_target[31] ^ branch_target[31];

  // Candidate next addresses and the redirect decision for this cycle
  always_comb begin
    run       = (state_q == RUN);
    user_mode = ~pc_q[31];
    seq_pc    = {pc_q[31], pc_q[30:0] + 31'd4};
    // User code may not raise itself into supervisor space through jr.
    jr_pc     = {jr_target[31] & pc_q[31], jr_target[30:0]};
    branch_pc = {pc_q[31], branch_target[30:0]};
    jump_pc   = {pc_q[31], jump_target[30:0]};

    // Where ordinary control flow goes, ignoring stall; this is also the
    // address an interrupt returns to.
    if (jr_en) begin
      flow_pc = jr_pc;
    end else if (branch_en) begin
      flow_pc = branch_pc;
    end else if (jump_en) begin
      flow_pc = jump_pc;
    end else begin
      flow_pc = seq_pc;
    end

    flow_redirect = jr_en | branch_en | jump_en;
    irq_take      = run & irq & user_mode & ~exception;
    redirect      = run & (exception | irq_take | flow_redirect);
  end

  // Next-state selection by priority: exception, irq, jr/branch/jump, stall, pc+4
  always_comb begin
    state_d     = RUN;
    pc_d        = pc_q;
    epc_d       = epc_q;
    epc_we_d    = 1'b0;
    fetch_cnt_d = fetch_cnt_q;

    if (run) begin
      if (exception) begin
        pc_d     = EXC_VEC;
        epc_d    = exc_pc;
        epc_we_d = 1'b1;
      end else if (irq_take) begin
        pc_d     = IRQ_VEC;
        epc_d    = flow_pc;
        epc_we_d = 1'b1;
      end else if (flow_redirect) begin
        pc_d = flow_pc;
      end else if (!stall) begin
        pc_d = seq_pc;
      end

      // Redirects always advance, even when the pipeline asks to stall.
      if (redirect || !stall) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      epc_q       <= 32'h0;
      epc_we_q    <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      epc_we_q    <= epc_we_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign fetch_valid = (state_q == RUN);
  assign flush_if    = redirect;
  assign epc         = epc_q;
  assign epc_we      = epc_we_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the PC sequencing rules.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_V  = 32'h8000_0004;
  localparam logic [31:0] EXC_V  = 32'h8000_0008;
  localparam logic [31:0] MSB    = 32'h8000_0000;
  localparam logic [31:0] LOW31  = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        exception;
  logic [31:0] exc_pc;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_if;
  logic [31:0] epc;
  logic        epc_we;
  logic [31:0] fetch_cnt;

  fetch_pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .exception     (exception),
    .exc_pc        (exc_pc),
    .irq           (irq),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .flush_if      (flush_if),
    .epc           (epc),
    .epc_we        (epc_we),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_we;
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // pc + 4 inside the current half of the address space
  function automatic logic [31:0] next_seq(input logic [31:0] a);
    return (a & MSB) | ((a + 32'd4) & LOW31);
  endfunction

  task automatic idle();
    reset         = 1'b1;
    stall         = 1'b0;
    jump_en       = 1'b0;
    jump_target   = 32'h0;
    branch_en     = 1'b0;
    branch_target = 32'h0;
    jr_en         = 1'b0;
    jr_target     = 32'h0;
    exception     = 1'b0;
    exc_pc        = 32'h0;
    irq           = 1'b0;
  endtask

  // One clock: check combinational outputs, advance model and DUT, check state.
  task automatic tick();
    logic [31:0] tgt;
    logic [31:0] n_pc;
    logic [31:0] n_epc;
    logic [31:0] n_cnt;
    bit          n_run;
    bit          n_we;
    bit          irq_ok;
    bit          redir;
    #1;
    if (jr_en)
      tgt = m_pc[31] ? jr_target : (jr_target & LOW31);
    else if (branch_en)
      tgt = (m_pc & MSB) | (branch_target & LOW31);
    else if (jump_en)
      tgt = (m_pc & MSB) | (jump_target & LOW31);
    else
      tgt = next_seq(m_pc);
    irq_ok = irq && (m_pc < MSB);
    redir  = m_run && (exception || irq_ok || jr_en || branch_en || jump_en);

    check_eq("flush_if", {31'd0, flush_if}, {31'd0, redir});
    check_eq("pc_plus4", pc_plus4, next_seq(m_pc));

    n_run = m_run;
    n_pc  = m_pc;
    n_epc = m_epc;
    n_cnt = m_cnt;
    n_we  = 1'b0;
    if (!reset) begin
      n_run = 1'b0;
      n_pc  = RST_PC;
      n_epc = 32'h0;
      n_cnt = 32'h0;
    end else if (!m_run) begin
      n_run = 1'b1;
    end else begin
      if (exception) begin
        n_pc = EXC_V; n_epc = exc_pc; n_we = 1'b1;
      end else if (irq_ok) begin
        n_pc = IRQ_V; n_epc = tgt; n_we = 1'b1;
      end else if (jr_en || branch_en || jump_en) begin
        n_pc = tgt;
      end else if (!stall) begin
        n_pc = tgt;
      end
      if (redir || !stall) n_cnt = m_cnt + 32'd1;
    end

    @(posedge clk);
    #1;
    m_run = n_run;
    m_pc  = n_pc;
    m_epc = n_epc;
    m_we  = n_we;
    m_cnt = n_cnt;

    check_eq("pc", pc, m_pc);
    check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_run});
    check_eq("epc", epc, m_epc);
    check_eq("epc_we", {31'd0, epc_we}, {31'd0, m_we});
    check_eq("fetch_cnt", fetch_cnt, m_cnt);
    $display("t=%0t pc=%08h fv=%0b flush=%0b epc=%08h we=%0b cnt=%0d",
             $time, pc, fetch_valid, flush_if, epc, epc_we, fetch_cnt);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_run = 1'b0;
    m_pc  = RST_PC;
    m_epc = 32'h0;
    m_we  = 1'b0;
    m_cnt = 32'h0;

    // Reset held three cycles, then boot and sequential fetch
    reset = 1'b0;
    repeat (3) tick();
    check_eq("rst_pc", pc, 32'h8000_0000);
    check_eq("rst_fv", {31'd0, fetch_valid}, 32'd0);
    reset = 1'b1;
    tick();                      // BOOT -> RUN, pc held at reset vector
    check_eq("run_pc", pc, 32'h8000_0000);
    tick();
    check_eq("seq_pc1", pc, 32'h8000_0004);
    tick();
    check_eq("seq_pc2", pc, 32'h8000_0008);
    tick();
    check_eq("seq_pc3", pc, 32'h8000_000C);

    // Two-cycle stall
    stall = 1'b1;
    tick();
    tick();
    check_eq("stall_pc", pc, 32'h8000_000C);
    check_eq("stall_cnt", fetch_cnt, 32'd3);
    stall = 1'b0;
    tick();
    check_eq("post_stall_pc", pc, 32'h8000_0010);

    // Branch beats jump in the same cycle
    branch_en = 1'b1; branch_target = 32'h0000_0040;
    jump_en   = 1'b1; jump_target   = 32'h0000_0080;
    tick();
    check_eq("br_jmp_pc", pc, 32'h8000_0040);

    // Drop to user mode, then a jr that tries to reach supervisor space
    idle(); jr_en = 1'b1; jr_target = 32'h0000_0020;
    tick();
    check_eq("to_user_pc", pc, 32'h0000_0020);
    jr_target = 32'h8000_0100;
    tick();
    check_eq("jr_priv_pc", pc, 32'h0000_0100);

    // Interrupt alongside a branch in user mode
    idle(); jump_en = 1'b1; jump_target = 32'h0000_0030;
    tick();
    idle(); irq = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_0050;
    tick();
    check_eq("irq_pc", pc, 32'h8000_0004);
    check_eq("irq_epc", epc, 32'h0000_0050);
    check_eq("irq_we", {31'd0, epc_we}, 32'd1);
    idle();
    tick();

    // Same interrupt in supervisor mode is ignored
    jump_en = 1'b1; jump_target = 32'h0000_0030;
    tick();
    check_eq("sup_pc", pc, 32'h8000_0030);
    idle(); irq = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_0050;
    tick();
    check_eq("sup_irq_pc", pc, 32'h8000_0050);

    // Exception with irq and stall, then reset mid-redirect
    idle(); jr_en = 1'b1; jr_target = 32'h0000_0040;
    tick();
    idle(); exception = 1'b1; irq = 1'b1; stall = 1'b1; exc_pc = 32'h0000_002C;
    tick();
    check_eq("exc_pc", pc, 32'h8000_0008);
    check_eq("exc_epc", epc, 32'h0000_002C);
    idle(); branch_en = 1'b1; branch_target = 32'h0000_0200; reset = 1'b0;
    tick();
    check_eq("mid_rst_pc", pc, 32'h8000_0000);
    idle();
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      jump_en       = ($urandom_range(0, 7) == 0);
      jump_target   = $urandom & 32'hFFFF_FFFC;
      branch_en     = ($urandom_range(0, 7) == 0);
      branch_target = $urandom & 32'hFFFF_FFFC;
      jr_en         = ($urandom_range(0, 7) == 0);
      jr_target     = $urandom & 32'hFFFF_FFFC;
      exception     = ($urandom_range(0, 15) == 0);
      exc_pc        = $urandom & 32'hFFFF_FFFC;
      irq           = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
